// File: rtl/instruction_fetch_if.sv
// ============================================================================
// instruction_fetch_if : instruction RAM, redirect and decode handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_if #(
   parameter int ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           iRAMOutput;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  instr_ready;
   logic                  instr_valid;
   logic [31:0]           instr_word;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  halted;
   logic                  fetch_fault;
   logic [15:0]           fetch_count;

   modport master (
      output address, instr_valid, instr_word, instr_pc, halted, fetch_fault, fetch_count,
      input  iRAMOutput, redirect_valid, redirect_target, instr_ready
   );

   modport slave (
      input  address, instr_valid, instr_word, instr_pc, halted, fetch_fault, fetch_count,
      output iRAMOutput, redirect_valid, redirect_target, instr_ready
   );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : PC sequencer with one-entry output register, redirect,
// halt and out-of-range fault. Optional macro: JUMP_PREDECODE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
   parameter int ADDR_WIDTH = 10,
   parameter int RAM_DEPTH  = 160,
   parameter int START_ADDR = 0
) (
   input  wire                  clock,
   input  wire                  reset,
   instruction_fetch_if.master  bus
);
   localparam int unsigned c_ram_depth = RAM_DEPTH;
   localparam logic [5:0]  c_op_hlt    = 6'b011100;
   localparam logic [5:0]  c_op_jump   = 6'b010101;

   typedef enum logic [0:0] {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  instr_valid_q, instr_valid_d;
   logic [31:0]           instr_word_q, instr_word_d;
   logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic                  fetch_fault_q, fetch_fault_d;
   logic [15:0]           fetch_count_q, fetch_count_d;
   logic                  load;
   logic                  pc_in_range;
   logic [5:0]            opcode;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= ADDR_WIDTH'(START_ADDR);
         instr_valid_q <= 1'b0;
         instr_word_q  <= 32'd0;
         instr_pc_q    <= '0;
         fetch_fault_q <= 1'b0;
         fetch_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
         instr_word_q  <= instr_word_d;
         instr_pc_q    <= instr_pc_d;
         fetch_fault_q <= fetch_fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_valid_d = instr_valid_q;
      instr_word_d  = instr_word_q;
      instr_pc_d    = instr_pc_q;
      fetch_fault_d = fetch_fault_q;
      fetch_count_d = fetch_count_q;
      load          = 1'b0;
      pc_in_range   = (32'(pc_q) < c_ram_depth);
      opcode        = bus.iRAMOutput[31:26];

      // Redirect outranks both the range check and a pending Hlt on the RAM bus.
      if (state_q == FETCH) begin
         if (bus.redirect_valid) begin
            pc_d          = bus.redirect_target;
            instr_valid_d = 1'b0;
         end else if (!pc_in_range) begin
            fetch_fault_d = 1'b1;
            state_d       = HALTED;
         end else if (!instr_valid_q || bus.instr_ready) begin
            load = 1'b1;
         end
      end

      if (load) begin
         instr_word_d  = bus.iRAMOutput;
         instr_pc_d    = pc_q;
         instr_valid_d = 1'b1;
         pc_d          = pc_q + ADDR_WIDTH'(1);
         if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
         end
         if (opcode == c_op_hlt) begin
            state_d = HALTED;
         end
`ifdef JUMP_PREDECODE_EN
         if (opcode == c_op_jump) begin
            pc_d = bus.iRAMOutput[ADDR_WIDTH-1:0];
         end
`else
         if (opcode == c_op_jump) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
         end
`endif
      end else if (instr_valid_q && bus.instr_ready) begin
         instr_valid_d = 1'b0;
      end
   end

   assign bus.address     = pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_word  = instr_word_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.halted      = (state_q == HALTED);
   assign bus.fetch_fault = fetch_fault_q;
   assign bus.fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : directed checks of instruction_fetch (two instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] HLT  = 32'h7000_0000;
   localparam logic [31:0] JMP84 = 32'h5400_0054;

   logic clock = 1'b0;
   logic reset_a = 1'b1;
   logic reset_b = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic [31:0] rom [0:1023];

   always #5 clock = ~clock;

   instruction_fetch_if #(.ADDR_WIDTH(10)) bus_a ();
   instruction_fetch_if #(.ADDR_WIDTH(10)) bus_b ();

   assign bus_a.iRAMOutput = rom[bus_a.address];
   assign bus_b.iRAMOutput = NOP;

   instruction_fetch #(.ADDR_WIDTH(10), .RAM_DEPTH(160), .START_ADDR(0)) dut_a (
      .clock (clock),
      .reset (reset_a),
      .bus   (bus_a.master)
   );

   instruction_fetch #(.ADDR_WIDTH(10), .RAM_DEPTH(4), .START_ADDR(0)) dut_b (
      .clock (clock),
      .reset (reset_b),
      .bus   (bus_b.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, " valid"}, 32'(bus_a.instr_valid), 32'd0);
      check({tag, " word"},  bus_a.instr_word, 32'd0);
      check({tag, " pc"},    32'(bus_a.instr_pc), 32'd0);
      check({tag, " halt"},  32'(bus_a.halted), 32'd0);
      check({tag, " fault"}, 32'(bus_a.fetch_fault), 32'd0);
      check({tag, " count"}, 32'(bus_a.fetch_count), 32'd0);
      check({tag, " addr"},  32'(bus_a.address), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = NOP;
      rom[2] = HLT;
      bus_a.redirect_valid  = 1'b0;
      bus_a.redirect_target = '0;
      bus_a.instr_ready     = 1'b1;
      bus_b.redirect_valid  = 1'b0;
      bus_b.redirect_target = '0;
      bus_b.instr_ready     = 1'b1;

      // Reset state
      step(2);
      check_reset_a("rst");

      // Nop, Nop, Hlt with ready held high
      reset_a = 1'b0;
      step(1);
      check("seq0 pc", 32'(bus_a.instr_pc), 32'd0);
      check("seq0 valid", 32'(bus_a.instr_valid), 32'd1);
      check("seq0 addr", 32'(bus_a.address), 32'd1);
      step(1);
      check("seq1 pc", 32'(bus_a.instr_pc), 32'd1);
      step(1);
      check("seq2 pc", 32'(bus_a.instr_pc), 32'd2);
      check("seq2 word", bus_a.instr_word, HLT);
      check("seq2 halt", 32'(bus_a.halted), 32'd1);
      check("seq2 addr", 32'(bus_a.address), 32'd3);
      check("seq2 count", 32'(bus_a.fetch_count), 32'd3);

      // Halted with a live word held by back-pressure, then reset pulse
      bus_a.instr_ready = 1'b0;
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_target = 10'd50;
      step(1);
      check("hold valid", 32'(bus_a.instr_valid), 32'd1);
      check("hold halt", 32'(bus_a.halted), 32'd1);
      check("hold addr ignores redirect", 32'(bus_a.address), 32'd3);
      bus_a.redirect_valid = 1'b0;
      reset_a = 1'b1;
      rom[2] = NOP;
      step(1);
      check_reset_a("rst2");
      reset_a = 1'b0;
      bus_a.instr_ready = 1'b1;
      step(1);
      check("resume pc", 32'(bus_a.instr_pc), 32'd0);
      check("resume count", 32'(bus_a.fetch_count), 32'd1);

      // Back-pressure stall with word at PC 5
      step(5);
      check("pre-stall pc", 32'(bus_a.instr_pc), 32'd5);
      check("pre-stall count", 32'(bus_a.fetch_count), 32'd6);
      bus_a.instr_ready = 1'b0;
      step(3);
      check("stall pc", 32'(bus_a.instr_pc), 32'd5);
      check("stall addr", 32'(bus_a.address), 32'd6);
      check("stall count", 32'(bus_a.fetch_count), 32'd6);
      check("stall valid", 32'(bus_a.instr_valid), 32'd1);
      bus_a.instr_ready = 1'b1;
      step(1);
      check("unstall pc", 32'(bus_a.instr_pc), 32'd6);
      check("unstall count", 32'(bus_a.fetch_count), 32'd7);

      // Redirect while Hlt sits on the RAM output
      rom[7] = HLT;
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_target = 10'd69;
      step(1);
      check("redir valid", 32'(bus_a.instr_valid), 32'd0);
      check("redir addr", 32'(bus_a.address), 32'd69);
      check("redir halt", 32'(bus_a.halted), 32'd0);
      check("redir count", 32'(bus_a.fetch_count), 32'd7);
      bus_a.redirect_valid = 1'b0;
      step(1);
      check("post-redir pc", 32'(bus_a.instr_pc), 32'd69);
      check("post-redir count", 32'(bus_a.fetch_count), 32'd8);
      rom[7] = NOP;

      // Jump predecode
      reset_a = 1'b1;
      rom[1] = JMP84;
      step(1);
      reset_a = 1'b0;
      step(2);
      check("jmp pc1", 32'(bus_a.instr_pc), 32'd1);
      check("jmp word", bus_a.instr_word, JMP84);
      step(1);
`ifdef JUMP_PREDECODE_EN
      check("jmp next pc", 32'(bus_a.instr_pc), 32'd84);
`else
      check("jmp next pc", 32'(bus_a.instr_pc), 32'd2);
`endif

      // Out-of-range fault with RAM_DEPTH=4
      reset_b = 1'b0;
      step(4);
      check("oor pc3", 32'(bus_b.instr_pc), 32'd3);
      check("oor fault early", 32'(bus_b.fetch_fault), 32'd0);
      check("oor addr", 32'(bus_b.address), 32'd4);
      step(1);
      check("oor fault", 32'(bus_b.fetch_fault), 32'd1);
      check("oor halt", 32'(bus_b.halted), 32'd1);
      check("oor valid drained", 32'(bus_b.instr_valid), 32'd0);
      check("oor count", 32'(bus_b.fetch_count), 32'd4);
      bus_b.redirect_valid = 1'b1;
      bus_b.redirect_target = 10'd0;
      step(2);
      check("oor addr frozen", 32'(bus_b.address), 32'd4);
      check("oor count frozen", 32'(bus_b.fetch_count), 32'd4);
      check("oor still halted", 32'(bus_b.halted), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning instruction address width.
REQ-002 SHALL have parameter RAM_DEPTH, default 160, meaning number of valid instruction words; addresses >= RAM_DEPTH are out of range.
REQ-003 SHALL have parameter START_ADDR, default 0, meaning PC value loaded on reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port address, output, ADDR_WIDTH, current PC driven to the instruction RAM.
REQ-007 SHALL have port iRAMOutput, input, 32, instruction word returned combinationally for address.
REQ-008 SHALL have port redirect_valid, input, 1, downstream request to change PC (taken branch, register jump).
REQ-009 SHALL have port redirect_target, input, ADDR_WIDTH, new PC when redirect_valid=1.
REQ-010 SHALL have port instr_ready, input, 1, decoder accepts instr_word this cycle.
REQ-011 SHALL have port instr_valid, output, 1, instr_word/instr_pc hold a live instruction.
REQ-012 SHALL have port instr_word, output, 32, registered instruction.
REQ-013 SHALL have port instr_pc, output, ADDR_WIDTH, address instr_word was fetched from.
REQ-014 SHALL have port halted, output, 1, high in HALTED state.
REQ-015 SHALL have port fetch_fault, output, 1, sticky; PC went out of range.
REQ-016 SHALL have port fetch_count, output, 16, count of instructions loaded into instr_word, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement states FETCH and HALTED; address = PC at all times.
REQ-018 "Load" condition SHALL be: state FETCH, redirect_valid=0, PC < RAM_DEPTH, and (instr_valid=0 or instr_ready=1).
REQ-019 On load, SHALL register instr_word<=iRAMOutput, instr_pc<=PC, instr_valid<=1, PC<=PC+1 (modulo 2^ADDR_WIDTH), fetch_count+=1; latency address->instr_word is one cycle.
REQ-020 When instr_valid=1, instr_ready=1 and no load, SHALL clear instr_valid next cycle.
REQ-021 When instr_valid=1 and instr_ready=0, instr_word, instr_pc, PC SHALL hold (back-pressure stall).
REQ-022 redirect_valid=1 SHALL have priority over all other events: PC<=redirect_target, instr_valid<=0 (flush), no load, no count increment, state FETCH->FETCH.
REQ-023 When a loaded word has opcode bits[31:26]=6'b011100 (Hlt), SHALL enter HALTED with PC frozen at Hlt address+1; the Hlt word is still delivered via handshake.
REQ-024 Simultaneous redirect_valid and Hlt present on iRAMOutput SHALL perform the redirect and not halt.
REQ-025 In FETCH with PC >= RAM_DEPTH and no redirect, SHALL set fetch_fault, enter HALTED, not load.
REQ-026 HALTED SHALL be terminal until reset; redirect_valid ignored; pending instr_valid still drains via instr_ready.
REQ-027 halted SHALL be 1 exactly while state is HALTED.

Reset
REQ-028 Reset SHALL set PC=START_ADDR, state FETCH, instr_valid=0, instr_word=0, instr_pc=0, halted=0, fetch_fault=0, fetch_count=0.
REQ-029 Reset asserted mid-operation (stall, halted, faulted) SHALL override all other inputs that cycle; first load occurs the cycle after reset deasserts.

Configuration
REQ-030 Macro JUMP_PREDECODE_EN, when defined, SHALL on load of opcode 6'b010101 (Jump) set PC<=word[ADDR_WIDTH-1:0] instead of PC+1; the Jump word is still delivered.
REQ-031 Without JUMP_PREDECODE_EN, Jump SHALL be treated as any other word (PC+1); downstream redirects it.

Verification
REQ-032 Reset, ROM 0:Nop,1:Nop,2:Hlt, instr_ready=1 -> instr_pc 0,1,2 on consecutive cycles, halted=1 after 2, fetch_count=3.
REQ-033 instr_ready=0 for 3 cycles with word at PC 5 valid -> instr_pc stays 5, address stays 6, fetch_count unchanged.
REQ-034 redirect_valid=1, target 69 while Hlt on iRAMOutput -> instr_valid=0 next cycle, address=69, halted=0.
REQ-035 RAM_DEPTH=4, all Nop -> loads 0..3, then fetch_fault=1, halted=1, address=4, no further loads.
REQ-036 JUMP_PREDECODE_EN defined, word 1 = Jump #84 -> instr_pc 1 followed by instr_pc 84; undefined -> followed by instr_pc 2.
REQ-037 Reset pulse while halted with instr_valid=1 -> all outputs at reset values next cycle, fetch resumes at START_ADDR.
